sprite_tile_writer: RTL and testbench
=====================================

Name: sprite_tile_writer

Overview:
- Write-side counterpart of the sprite pixel-address generator. It accepts a stream of 12-bit RGB pixels over a valid/ready handshake and writes one TILE_W x TILE_H tile into the write port of the sprite block RAM.
- Uses the same row-major layout the display path reads: address = base + row*TILE_W + col.
- Sits between the sprite loader (UART/ROM copy logic) and port A of the dual-port sprite memory. The VGA read path keeps port B.

Parameters:
- TILE_W, 20, tile width in pixels
- TILE_H, 20, tile height in pixels
- ADDR_W, 17, sprite memory address width
- DATA_W, 12, pixel width (4:4:4 RGB)
- KEY_COLOR, 12'h0F0, transparent colour (used only by the optional feature)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request to begin a tile; sampled only in IDLE
- base_addr  in  ADDR_W  tile origin in sprite memory; latched on accepted start
- pix_valid  in  1  source has a pixel on pix_data
- pix_data  in  DATA_W  pixel, row-major, col 0 first
- pix_ready  out  1  block can accept a pixel this cycle
- wea  out  1  memory write enable
- addra  out  ADDR_W  memory write address
- dina  out  DATA_W  memory write data
- busy  out  1  tile in progress
- done  out  1  one-cycle pulse: tile fully written

Behaviour:
- Reset: state=IDLE. All outputs 0: pix_ready, wea, addra, dina, busy, done. Counters col, row and the address accumulator are 0.
- FSM has three states: IDLE, WRITE, DONE.
- IDLE:
  - pix_ready=0; incoming pixels are ignored.
  - start=1 latches base_addr into the accumulator, clears col and row, then moves to WRITE.
- WRITE:
  - busy=1 and pix_ready=1, combinationally from state.
  - A beat is accepted when pix_valid and pix_ready are both 1 at a rising edge.
  - On acceptance, wea, addra and dina register the write; it is presented the cycle after acceptance (latency 1).
  - Cycles with no accepted beat drive wea=0 and hold addra/dina.
  - col increments on each accepted beat. When col==TILE_W-1 it wraps to 0 and row increments.
  - The accumulator increments by 1 per beat, so there is no multiplier. Address arithmetic is modulo 2^ADDR_W: base near the top wraps silently with no error.
  - Acceptance of the beat with row==TILE_H-1 and col==TILE_W-1 moves the FSM to DONE.
- DONE (exactly one cycle):
  - The final write is presented: wea=1, done=1, busy=1, pix_ready=0.
  - Next state is IDLE.
- start while busy (WRITE or DONE) is ignored and does not restart.
- A start in the same cycle that DONE exits to IDLE is ignored. start is only honoured in IDLE.
- The source may stall indefinitely with pix_valid=0; no timeout.
- pix_valid may drop between beats; acceptance is strictly per-handshake.
- Reset mid-tile: immediate return to IDLE with all outputs 0. Addresses already written stay written; the tile is left partial and done never pulses for it.
- Total writes per tile: exactly TILE_W*TILE_H (400 by default), regardless of stalls.

Optional Feature:
- Macro: SPRITE_TILE_WRITER_KEY_SKIP_EN.
- Defined: an accepted beat with pix_data==KEY_COLOR still advances col, row and the accumulator, but its write slot drives wea=0. Exception: if it is the final pixel, DONE still pulses done=1 with wea=0.
- Undefined: every accepted beat is written. KEY_COLOR is unused.

Decomposition:
- Shared package sprite_pkg holds:
  - TILE_W, TILE_H, ADDR_W, DATA_W defaults, shared with the read-side address generator so both agree on layout
  - the FSM state enum (IDLE, WRITE, DONE)
  - the KEY_COLOR default
- One natural sub-module, tile_pos_counter: col/row counter with wrap and a last-pixel flag, parameterised by TILE_W/TILE_H.

Test Plan:
- Reset, then start with base_addr=0. Stream 400 pixels with valid held high, data=index.
  - Expect wea pulses at addra 0..399 with dina==addra[11:0].
  - done=1 exactly once, on the cycle with addra=399.
  - busy falls the following cycle.
- base_addr=17'h1FFF8, back-to-back tile.
  - Expect addra 1FFF8..1FFFF, then wrap to 0..391.
  - 400 writes total.
- Random stalls: pix_valid low on 50% of cycles.
  - Expect the same 400 address/data pairs in order.
  - wea=0 on every stalled cycle.
  - No duplicate or skipped addresses.
- start pulsed at beat 100 of an active tile.
  - Ignored: the write sequence continues unbroken to 399, single done.
- rst asserted asynchronously after beat 150.
  - Outputs go to 0 immediately; done never pulses.
  - A new start then writes from base again at beat 0.
- With SPRITE_TILE_WRITER_KEY_SKIP_EN defined: pixels at indices 0, 21 and 399 equal 12'h0F0.
  - Those addresses see no wea.
  - The other 397 addresses are written.
  - done still pulses once.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared sprite memory layout and writer FSM definitions, common to the read and write paths.
package sprite_pkg;

  localparam int unsigned TILE_W_DEFAULT = 20;
  localparam int unsigned TILE_H_DEFAULT = 20;
  localparam int unsigned ADDR_W_DEFAULT = 17;
  localparam int unsigned DATA_W_DEFAULT = 12;

  localparam logic [11:0] KEY_COLOR_DEFAULT = 12'h0F0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } tile_state_t;

  // Counter width that stays at least 1 bit for degenerate 1-wide tiles.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tile_pos_counter.sv
// Row-major column/row position within a tile, with wrap and a last-pixel flag.
module tile_pos_counter
  import sprite_pkg::*;
#(
  parameter int unsigned TILE_W = TILE_W_DEFAULT,
  parameter int unsigned TILE_H = TILE_H_DEFAULT,
  localparam int unsigned COL_W = cnt_width(TILE_W),
  localparam int unsigned ROW_W = cnt_width(TILE_H)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             advance,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             last_c
);

  logic col_end_c;
  logic row_end_c;

  assign col_end_c = (col == COL_W'(TILE_W - 1));
  assign row_end_c = (row == ROW_W'(TILE_H - 1));
  assign last_c    = col_end_c && row_end_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
    end else if (advance) begin
      if (col_end_c) begin
        col <= '0;
        row <= row_end_c ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/sprite_tile_writer.sv
// Streams one TILE_W x TILE_H tile of pixels into the sprite RAM write port, row-major from base_addr.
// Optional SPRITE_TILE_WRITER_KEY_SKIP_EN: pixels equal to KEY_COLOR advance the address but are not written.
module sprite_tile_writer
  import sprite_pkg::*;
#(
  parameter int unsigned        TILE_W    = TILE_W_DEFAULT,
  parameter int unsigned        TILE_H    = TILE_H_DEFAULT,
  parameter int unsigned        ADDR_W    = ADDR_W_DEFAULT,
  parameter int unsigned        DATA_W    = DATA_W_DEFAULT,
  parameter logic [DATA_W-1:0]  KEY_COLOR = DATA_W'(KEY_COLOR_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] pix_data,
  output logic              pix_ready,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina,
  output logic              busy,
  output logic              done
);

  localparam int unsigned COL_W = cnt_width(TILE_W);
  localparam int unsigned ROW_W = cnt_width(TILE_H);

  tile_state_t       state;
  tile_state_t       state_n;
  logic [ADDR_W-1:0] acc;
  logic              load_c;
  logic              accept_c;
  logic              last_c;
  logic              write_en_c;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic              unused_pos;

  assign load_c   = (state == IDLE) && start;
  assign accept_c = (state == WRITE) && pix_valid && pix_ready;

`ifdef SPRITE_TILE_WRITER_KEY_SKIP_EN
  assign write_en_c = (pix_data != KEY_COLOR);
`else
  logic unused_key;
  assign unused_key = ^KEY_COLOR;
  assign write_en_c = 1'b1;
`endif

  // Position is tracked for the last-pixel flag only; the address comes from the accumulator.
  assign unused_pos = ^{col, row};

  tile_pos_counter #(
    .TILE_W (TILE_W),
    .TILE_H (TILE_H)
  ) u_pos (
    .clk     (clk),
    .rst     (rst),
    .clear   (load_c),
    .advance (accept_c),
    .col     (col),
    .row     (row),
    .last_c  (last_c)
  );

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = WRITE;
      WRITE:   if (accept_c && last_c) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State, status flags derived from the next state, and the write port registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pix_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wea       <= 1'b0;
      addra     <= '0;
      dina      <= '0;
      acc       <= '0;
    end else begin
      state     <= state_n;
      busy      <= (state_n != IDLE);
      pix_ready <= (state_n == WRITE);
      done      <= (state_n == DONE);
      wea       <= accept_c && write_en_c;
      if (load_c) begin
        acc <= base_addr;
      end else if (accept_c) begin
        acc <= acc + ADDR_W'(1);
      end
      if (accept_c) begin
        addra <= acc;
        dina  <= pix_data;
      end
    end
  end

endmodule

// File: tb/tb_sprite_tile_writer.sv
// Directed bench for sprite_tile_writer: full tiles, address wrap, stalls, ignored starts, mid-tile reset.
module tb_sprite_tile_writer;
  import sprite_pkg::*;

  localparam int unsigned ADDR_W = 17;
  localparam int unsigned DATA_W = 12;
  localparam int          NPIX   = 400;
`ifdef SPRITE_TILE_WRITER_KEY_SKIP_EN
  localparam bit KEY_BUILD = 1'b1;
`else
  localparam bit KEY_BUILD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              pix_valid;
  logic [DATA_W-1:0] pix_data;
  logic              pix_ready;
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [DATA_W-1:0] dina;
  logic              busy;
  logic              done;

  int n_checks = 0;
  int n_errors = 0;

  sprite_tile_writer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .pix_ready (pix_ready),
    .wea       (wea),
    .addra     (addra),
    .dina      (dina),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Key-mode tiles mark indices 0, 21, 399 transparent and keep every other pixel away from the key.
  function automatic logic [DATA_W-1:0] pix_of(input int idx, input bit key_mode);
    if (key_mode && (idx == 0 || idx == 21 || idx == 399)) return DATA_W'(KEY_COLOR_DEFAULT);
    if (key_mode) return DATA_W'(idx) | 12'h800;
    return DATA_W'(idx);
  endfunction

  function automatic bit is_skipped(input logic [DATA_W-1:0] d);
    return KEY_BUILD && (d == DATA_W'(KEY_COLOR_DEFAULT));
  endfunction

  function automatic int expected_writes(input bit key_mode);
    int n = 0;
    for (int i = 0; i < NPIX; i++) begin
      if (!is_skipped(pix_of(i, key_mode))) n++;
    end
    return n;
  endfunction

  task automatic run_tile(input logic [ADDR_W-1:0] base, input bit stall, input int start_at,
                          input int rst_at, input bit key_mode);
    int                sent;
    int                cyc;
    int                done_cnt;
    int                wr_cnt;
    bit                v;
    bit                rdy;
    bit                accepted;
    bit                pulsed;
    logic [DATA_W-1:0] d;
    logic [ADDR_W-1:0] ea;

    start     = 1'b1;
    base_addr = base;
    pix_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("ready_after_start", 32'(pix_ready), 32'd1);

    sent = 0; cyc = 0; done_cnt = 0; wr_cnt = 0; pulsed = 1'b0;
    while (sent < NPIX && cyc < 4000) begin
      v         = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      d         = pix_of(sent, key_mode);
      pix_valid = v;
      pix_data  = v ? d : 12'hABC;
      rdy       = pix_ready;
      if (start_at >= 0 && sent == start_at && !pulsed) begin
        start     = 1'b1;
        base_addr = 17'h01234;
        pulsed    = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      accepted = v && rdy;
      check("wea", 32'(wea), 32'(accepted && !is_skipped(d)));
      if (accepted) begin
        ea = base + ADDR_W'(sent);
        if (!is_skipped(d)) begin
          check("addra", 32'(addra), 32'(ea));
          check("dina", 32'(dina), 32'(d));
          wr_cnt++;
        end
        sent++;
      end
      check("done", 32'(done), 32'(accepted && sent == NPIX));
      if (done) done_cnt++;
      check("busy", 32'(busy), 32'd1);
      if (accepted && rst_at >= 0 && sent == rst_at) begin
        #2 rst = 1'b1;
        #1;
        check("rst_wea", 32'(wea), 32'd0);
        check("rst_addra", 32'(addra), 32'd0);
        check("rst_dina", 32'(dina), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(pix_ready), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        check("rst_hold_done", 32'(done), 32'd0);
        check("rst_hold_busy", 32'(busy), 32'd0);
        rst       = 1'b0;
        pix_valid = 1'b0;
        return;
      end
    end
    pix_valid = 1'b0;
    check("beats", 32'(sent), 32'(NPIX));
    check("done_count", 32'(done_cnt), 32'd1);
    check("writes", 32'(wr_cnt), 32'(expected_writes(key_mode)));
    check("ready_in_done", 32'(pix_ready), 32'd0);

    // A start arriving while DONE exits must not begin a new tile.
    start     = 1'b1;
    base_addr = 17'h00555;
    @(posedge clk); #1;
    start = 1'b0;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_ready", 32'(pix_ready), 32'd0);
    check("idle_wea", 32'(wea), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    check("stays_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    pix_valid = 1'b0;
    pix_data  = '0;
    @(posedge clk); #1;
    check("reset_ready", 32'(pix_ready), 32'd0);
    check("reset_wea", 32'(wea), 32'd0);
    check("reset_addra", 32'(addra), 32'd0);
    check("reset_dina", 32'(dina), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    rst = 1'b0;

    pix_valid = 1'b1;
    pix_data  = 12'h005;
    @(posedge clk); #1;
    check("idle_ignore_ready", 32'(pix_ready), 32'd0);
    check("idle_ignore_wea", 32'(wea), 32'd0);
    check("idle_ignore_busy", 32'(busy), 32'd0);
    pix_valid = 1'b0;

    run_tile(17'h00000, 1'b0, -1, -1, 1'b0);
    run_tile(17'h1FFF8, 1'b0, -1, -1, 1'b0);
    run_tile(17'h00100, 1'b1, -1, -1, 1'b0);
    run_tile(17'h00000, 1'b0, 100, -1, 1'b0);
    run_tile(17'h00200, 1'b0, -1, 150, 1'b0);
    run_tile(17'h00200, 1'b0, -1, -1, 1'b0);
`ifdef SPRITE_TILE_WRITER_KEY_SKIP_EN
    run_tile(17'h00000, 1'b0, -1, -1, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
